aes_128_sched: RTL

//  Shares one fully pipelined aes_128 core (no valid/stall) among N_REQ requesters.

---
 rtl/aes_128_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/aes_128_sched.sv
// Round-robin scheduler sharing one non-stallable, fully pipelined aes_128 core among N_REQ requesters.
// A tag pipeline tracks block ownership; credits reserve FIFO space so no result is ever dropped.
module aes_128_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned IDW        = 2,
    parameter int unsigned LATENCY    = 21,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*128-1:0]   req_state,
    input  logic [N_REQ*128-1:0]   req_key,
    output logic [127:0]           core_state,
    output logic [127:0]           core_key,
    input  logic [127:0]           core_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [127:0]           rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt;
    logic [IDW-1:0]   ptr_nxt;
    logic             found;
    int unsigned      idx;
    logic             can_issue;
    logic             issue;
    logic             retire;
    logic             push;
    logic             pop;
    logic [127:0]     sel_state;
    logic [127:0]     sel_key;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [IDW:0]     tag_pipe [LATENCY];
    logic [IDW+127:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_state = '0;
        sel_key   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_state = req_state[i*128 +: 128];
                sel_key   = req_key[i*128 +: 128];
            end
        end
    end

    // Outstanding blocks plus queued results never exceed FIFO capacity.
    assign can_issue = ((CW+1)'(inflight) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);
    assign issue     = ~rst & can_issue & found;
    assign ptr_nxt   = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = issue && (gnt == IDW'(i));
        end
    end

    assign retire              = tag_pipe[LATENCY-1][IDW];
    assign push                = retire;
    assign rsp_valid           = (fifo_count != '0);
    assign pop                 = rsp_valid & rsp_ready;
    assign {rsp_id, rsp_data}  = fifo_mem[rd_ptr];
    assign busy                = (inflight != '0) | rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            core_state <= '0;
            core_key   <= '0;
            ptr        <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            if (issue) begin
                core_state <= sel_state;
                core_key   <= sel_key;
                ptr        <= ptr_nxt;
            end
            tag_pipe[0] <= issue ? {1'b1, gnt} : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            case ({issue, retire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                assert (pop || fifo_count != CW'(FIFO_DEPTH));
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {tag_pipe[LATENCY-1][IDW-1:0], core_out};
        end
    end

endmodule
